// File: rtl/led_pattern_driver.sv
// Multi-channel LED driver: per-channel off/on/blink/breathe with PWM brightness,
// push-pull or open-drain pad drive selected per channel at elaboration.
module led_pattern_driver #(
    parameter int unsigned          NUM_LEDS      = 4,
    parameter int unsigned          CLK_FREQUENCY = 50000000,
    parameter int unsigned          TICK_RATE     = 1000,
    parameter int unsigned          PWM_BITS      = 8,
    parameter logic [NUM_LEDS-1:0]  OD_MASK       = '0
) (
    input  logic                         clk,
    input  logic                         rstN,
    input  logic [2*NUM_LEDS-1:0]        mode,
    input  logic [PWM_BITS*NUM_LEDS-1:0] brightness,
    input  logic [15:0]                  half_period,
    input  logic                         sync,
    output logic                         tick,
    output logic [NUM_LEDS-1:0]          led_o,
    output logic [NUM_LEDS-1:0]          led_t
);

    localparam int unsigned         TICK_DIVIDE = CLK_FREQUENCY / TICK_RATE;
    localparam int unsigned         PRE_W       = (TICK_DIVIDE > 2) ? $clog2(TICK_DIVIDE) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST    = PRE_W'(TICK_DIVIDE - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX     = '1;

    typedef enum logic {
        RAMP_UP   = 1'b0,
        RAMP_DOWN = 1'b1
    } ramp_dir_t;

    logic [PRE_W-1:0]                   prescaler;
    logic                               tick_en;
    logic [PWM_BITS-1:0]                pwm_count;
    logic [15:0]                        blink_count;
    logic [15:0]                        hp_m1;
    logic                               phase;
    logic [PWM_BITS-1:0]                ramp;
    logic [PWM_BITS-1:0]                ramp_next;
    ramp_dir_t                          dir;
    ramp_dir_t                          dir_next;
    logic [NUM_LEDS-1:0][PWM_BITS-1:0]  duty_d;
    logic [NUM_LEDS-1:0][PWM_BITS-1:0]  duty_q;
    logic [NUM_LEDS-1:0]                active;

    assign tick_en = (prescaler == PRE_LAST);
    // A zero half-period behaves like one tick.
    assign hp_m1   = (half_period == 16'd0) ? 16'd0 : half_period - 16'd1;

    // Timebase prescaler and registered tick pulse; sync restarts the timebase.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            prescaler <= '0;
            tick      <= 1'b0;
        end else begin
            tick <= tick_en & ~sync;
            if (sync || tick_en) prescaler <= '0;
            else                 prescaler <= prescaler + PRE_W'(1);
        end
    end

    // Free-running PWM counter.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)     pwm_count <= '0;
        else if (sync) pwm_count <= '0;
        else           pwm_count <= pwm_count + PWM_BITS'(1);
    end

    // Blink half-period counter and phase.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            blink_count <= '0;
            phase       <= 1'b0;
        end else if (sync) begin
            blink_count <= '0;
            phase       <= 1'b1;
        end else if (tick_en) begin
            if (blink_count >= hp_m1) begin
                blink_count <= '0;
                phase       <= ~phase;
            end else begin
                blink_count <= blink_count + 16'd1;
            end
        end
    end

    // Breathe ramp state register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            dir  <= RAMP_UP;
            ramp <= '0;
        end else begin
            dir  <= dir_next;
            ramp <= ramp_next;
        end
    end

    // Breathe ramp next state: triangle between 0 and PWM_MAX, one step per tick.
    always_comb begin
        dir_next  = dir;
        ramp_next = ramp;
        if (sync) begin
            dir_next  = RAMP_UP;
            ramp_next = '0;
        end else if (tick_en) begin
            unique case (dir)
                RAMP_UP: begin
                    ramp_next = ramp + PWM_BITS'(1);
                    if (ramp_next == PWM_MAX) dir_next = RAMP_DOWN;
                end
                RAMP_DOWN: begin
                    ramp_next = ramp - PWM_BITS'(1);
                    if (ramp_next == '0) dir_next = RAMP_UP;
                end
                default: dir_next = RAMP_UP;
            endcase
        end
    end

    // Per-channel duty selection from mode.
    always_comb begin
        duty_d = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            unique case (mode[2*i +: 2])
                2'b00: duty_d[i] = '0;
                2'b01: duty_d[i] = brightness[PWM_BITS*i +: PWM_BITS];
                2'b10: duty_d[i] = phase ? brightness[PWM_BITS*i +: PWM_BITS] : '0;
                default: duty_d[i] = (ramp < brightness[PWM_BITS*i +: PWM_BITS])
                                   ? ramp : brightness[PWM_BITS*i +: PWM_BITS];
            endcase
        end
    end

    // Duty pipeline register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) duty_q <= '0;
        else       duty_q <= duty_d;
    end

    // PWM compare; all-ones duty is fully on.
    always_comb begin
        active = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            active[i] = (pwm_count < duty_q[i]) || (duty_q[i] == PWM_MAX);
        end
    end

    // Pad output register: open-drain channels light the LED by releasing the pad.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            led_o <= '0;
            led_t <= '0;
        end else begin
            led_o <= active & ~OD_MASK;
            led_t <= active &  OD_MASK;
        end
    end

endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed bench for led_pattern_driver with a 10-clk tick and 4-bit PWM.
module tb_led_pattern_driver;

    localparam int unsigned N  = 4;
    localparam int unsigned PB = 4;

    logic              clk = 1'b0;
    logic              rstN;
    logic [2*N-1:0]    mode;
    logic [PB*N-1:0]   brightness;
    logic [15:0]       half_period;
    logic              sync;
    logic              tick;
    logic [N-1:0]      led_o;
    logic [N-1:0]      led_t;

    int tests = 0;
    int fails = 0;
    int n;

    led_pattern_driver #(
        .NUM_LEDS      (N),
        .CLK_FREQUENCY (100),
        .TICK_RATE     (10),
        .PWM_BITS      (PB),
        .OD_MASK       (4'b1000)
    ) dut (
        .clk         (clk),
        .rstN        (rstN),
        .mode        (mode),
        .brightness  (brightness),
        .half_period (half_period),
        .sync        (sync),
        .tick        (tick),
        .led_o       (led_o),
        .led_t       (led_t)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance k rising edges and land 1 time unit after the last one.
    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic [1:0] m, input logic [PB-1:0] b);
        mode[2*i +: 2]         = m;
        brightness[PB*i +: PB] = b;
    endtask

    task automatic count_high(input int idx, input int len, output int c);
        c = 0;
        repeat (len) begin
            step(1);
            if (led_o[idx]) c++;
        end
    endtask

    task automatic run_len(input int idx, output int len);
        logic v;
        v   = led_o[idx];
        len = 0;
        do begin
            step(1);
            len++;
        end while (led_o[idx] == v && len < 200);
    endtask

    task automatic wait_tick(output int len);
        len = 0;
        do begin
            step(1);
            len++;
        end while (!tick && len < 40);
    endtask

    task automatic pulse_sync();
        sync = 1'b1;
        step(1);
        sync = 1'b0;
    endtask

    initial begin
        rstN        = 1'b0;
        mode        = '0;
        brightness  = '0;
        half_period = 16'd3;
        sync        = 1'b0;

        // 1. reset values and tick period
        #23;
        check("rst_led_o", 32'(led_o), 0);
        check("rst_led_t", 32'(led_t), 0);
        check("rst_tick",  32'(tick),  0);
        @(posedge clk); #1;
        rstN = 1'b1;
        wait_tick(n);
        check("first_tick_delay", n, 10);
        step(1);
        check("tick_width", 32'(tick), 0);
        wait_tick(n);
        check("tick_period", n, 9);
        check("off_led_o", 32'(led_o), 0);

        // 2. steady-on PWM duty on ch0
        set_ch(0, 2'b01, 4'd4);
        step(3);
        count_high(0, 16, n);
        check("ch0_duty4", n, 4);
        set_ch(0, 2'b01, 4'd15);
        step(3);
        count_high(0, 16, n);
        check("ch0_duty15", n, 16);
        set_ch(0, 2'b01, 4'd0);
        step(3);
        count_high(0, 16, n);
        check("ch0_duty0", n, 0);
        check("ch0_led_t", 32'(led_t[0]), 0);

        // 3. blink on ch1
        set_ch(1, 2'b10, 4'd15);
        half_period = 16'd3;
        pulse_sync();
        run_len(1, n);
        run_len(1, n);
        run_len(1, n);
        check("blink3_low", n, 30);
        run_len(1, n);
        check("blink3_high", n, 30);
        half_period = 16'd0;
        run_len(1, n);
        run_len(1, n);
        check("blink0_run_a", n, 10);
        run_len(1, n);
        check("blink0_run_b", n, 10);

        // 5. open-drain ch3
        set_ch(3, 2'b01, 4'd15);
        step(3);
        count_high(3, 8, n);
        check("od_led_o_low", n, 0);
        check("od_led_t_high", 32'(led_t[3]), 1);
        set_ch(3, 2'b00, 4'd15);
        step(1);
        check("od_latency", 32'(led_t[3]), 1);
        step(1);
        check("od_off", 32'(led_t[3]), 0);

        // 4. breathe on ch2; probe points where pwm_count sits at 15 or 0
        set_ch(2, 2'b11, 4'd15);
        pulse_sync();
        step(144);
        check("ramp_14", 32'(led_o[2]), 0);
        step(16);
        check("ramp_15", 32'(led_o[2]), 1);
        step(16);
        check("ramp_13_down", 32'(led_o[2]), 0);
        step(113);
        check("ramp_2_down", 32'(led_o[2]), 1);
        step(16);
        check("ramp_0", 32'(led_o[2]), 0);
        step(16);
        check("ramp_1_up", 32'(led_o[2]), 1);
        set_ch(2, 2'b11, 4'd7);
        pulse_sync();
        step(100);
        count_high(2, 16, n);
        check("breathe_sat7", n, 7);

        // 6. asynchronous reset mid-blink and mid-ramp
        half_period = 16'd3;
        set_ch(1, 2'b10, 4'd15);
        set_ch(2, 2'b11, 4'd15);
        set_ch(3, 2'b01, 4'd15);
        pulse_sync();
        step(160);
        check("pre_rst_ramp", 32'(led_o[2]), 1);
        check("pre_rst_od", 32'(led_t[3]), 1);
        #2;
        rstN = 1'b0;
        #1;
        check("async_rst_led_o", 32'(led_o), 0);
        check("async_rst_led_t", 32'(led_t), 0);
        step(2);
        rstN = 1'b1;
        step(31);
        check("post_rst_phase0", 32'(led_o[1]), 0);
        step(1);
        check("post_rst_phase1", 32'(led_o[1]), 1);
        step(112);
        check("post_rst_ramp14", 32'(led_o[2]), 0);
        step(16);
        check("post_rst_ramp15", 32'(led_o[2]), 1);

        // sync coincident with tick_en suppresses the tick
        wait_tick(n);
        check("tick_align", 32'(tick), 1);
        step(9);
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        check("sync_blocks_tick", 32'(tick), 0);
        wait_tick(n);
        check("tick_after_sync", n, 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
